// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and defaults for the data-memory bus arbiter
package dmem_pkg;

    // Bus ownership: the CPU by default, the requester while a burst runs
    typedef enum logic {
        S_CPU = 1'b0,
        S_DMA = 1'b1
    } arb_state_t;

    localparam int BUS_W            = 32;
    localparam int STARVE_LIMIT_DEF = 8;
    localparam int BURST_W_DEF      = 4;

    // Width of the starvation counter; covers limits up to 255
    localparam int WAIT_W           = 8;

endpackage

// File: rtl/starve_counter.sv
// rtl/starve_counter.sv - saturating wait counter bounding requester starvation
//
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-high reset
//   inc_i  count one blocked cycle
//   clr_i  clear (takes priority over inc_i)
//   sat_o  counter has reached LIMIT
import dmem_pkg::*;

module starve_counter #(
    parameter int LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam logic [WAIT_W-1:0] LIM = WAIT_W'(LIMIT);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIM)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_o = (cnt_q == LIM);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master arbiter (CPU priority, bounded DMA wait) for the data-memory bus
//
// Ports:
//   clk_i, reset_i                  clock, asynchronous active-high reset
//   cpu_rd_i/wr_i/addr_i/wdata_i    CPU access request
//   cpu_rdata_o, cpu_stall_o        CPU read data (0 unless owner), PC hold
//   dma_req_i/wr_i/addr_i/wdata_i   requester beat; dma_req_i held until done
//   dma_burst_i                     beats minus 1, sampled on grant
//   dma_gnt_o, dma_rdata_o          requester owns bus, requester read data
//   dma_done_o                      final beat of the burst
//   mem_rd_o/wr_o/addr_o/wdata_o    shared bus
//   mem_rdata_i                     OR-combined slave read data
import dmem_pkg::*;

module dmem_arbiter #(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int BURST_W      = BURST_W_DEF
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               cpu_rd_i,
    input  logic               cpu_wr_i,
    input  logic [BUS_W-1:0]   cpu_addr_i,
    input  logic [BUS_W-1:0]   cpu_wdata_i,
    output logic [BUS_W-1:0]   cpu_rdata_o,
    output logic               cpu_stall_o,
    input  logic               dma_req_i,
    input  logic               dma_wr_i,
    input  logic [BUS_W-1:0]   dma_addr_i,
    input  logic [BUS_W-1:0]   dma_wdata_i,
    input  logic [BURST_W-1:0] dma_burst_i,
    output logic               dma_gnt_o,
    output logic [BUS_W-1:0]   dma_rdata_o,
    output logic               dma_done_o,
    output logic               mem_rd_o,
    output logic               mem_wr_o,
    output logic [BUS_W-1:0]   mem_addr_o,
    output logic [BUS_W-1:0]   mem_wdata_o,
    input  logic [BUS_W-1:0]   mem_rdata_i
);

    arb_state_t         state_q, state_d;
    logic [BURST_W-1:0] beat_cnt_q, beat_cnt_d;

    logic cpu_access;
    logic wait_sat;
    logic grant;
    logic last_beat;

    assign cpu_access = cpu_rd_i | cpu_wr_i;

    // Idle CPU hands over at once; a busy CPU only loses the bus once the
    // requester has waited STARVE_LIMIT cycles.
    assign grant     = (state_q == S_CPU) && dma_req_i && (!cpu_access || wait_sat);
    assign last_beat = (state_q == S_DMA) && dma_req_i && (beat_cnt_q == '0);

    starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk_i (clk_i),
        .rst_i (reset_i),
        .inc_i ((state_q == S_CPU) && dma_req_i && cpu_access && !grant),
        .clr_i (!dma_req_i || grant),
        .sat_o (wait_sat)
    );

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            S_CPU: begin
                if (grant) begin
                    state_d    = S_DMA;
                    beat_cnt_d = dma_burst_i;
                end
            end
            S_DMA: begin
                // Completion and abort both return to S_CPU, which guarantees
                // the CPU at least one cycle between bursts.
                if (!dma_req_i || last_beat) begin
                    state_d    = S_CPU;
                    beat_cnt_d = '0;
                end else begin
                    beat_cnt_d = beat_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d    = S_CPU;
                beat_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_CPU;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        mem_rd_o    = cpu_rd_i;
        mem_wr_o    = cpu_wr_i;
        mem_addr_o  = cpu_addr_i;
        mem_wdata_o = cpu_wdata_i;
        cpu_rdata_o = mem_rdata_i;
        cpu_stall_o = 1'b0;
        dma_gnt_o   = 1'b0;
        dma_rdata_o = '0;
        dma_done_o  = 1'b0;
        if (state_q == S_DMA) begin
            mem_rd_o    = dma_req_i & ~dma_wr_i;
            mem_wr_o    = dma_req_i & dma_wr_i;
            mem_addr_o  = dma_addr_i;
            mem_wdata_o = dma_wdata_i;
            cpu_rdata_o = '0;
            cpu_stall_o = cpu_access;
            dma_gnt_o   = dma_req_i;
            dma_rdata_o = mem_rdata_i;
            dma_done_o  = last_beat;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
import dmem_pkg::*;

module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_rd, cpu_wr;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dma_req, dma_wr;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic [3:0]  dma_burst;
    logic        dma_gnt, dma_done;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    // Combinational slave: read data is a fixed function of the address
    assign mem_rdata = mem_addr ^ 32'hDEAD_0000;

    dmem_arbiter #(
        .STARVE_LIMIT (8),
        .BURST_W      (4)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .cpu_rd_i    (cpu_rd),
        .cpu_wr_i    (cpu_wr),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_rdata_o (cpu_rdata),
        .cpu_stall_o (cpu_stall),
        .dma_req_i   (dma_req),
        .dma_wr_i    (dma_wr),
        .dma_addr_i  (dma_addr),
        .dma_wdata_i (dma_wdata),
        .dma_burst_i (dma_burst),
        .dma_gnt_o   (dma_gnt),
        .dma_rdata_o (dma_rdata),
        .dma_done_o  (dma_done),
        .mem_rd_o    (mem_rd),
        .mem_wr_o    (mem_wr),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        dma_req   = 1'b0;
        dma_wr    = 1'b0;
        dma_addr  = '0;
        dma_wdata = '0;
        dma_burst = '0;
        #12;

        // Reset state
        chk1("rst_gnt", dma_gnt, 1'b0);
        chk1("rst_done", dma_done, 1'b0);
        chk1("rst_stall", cpu_stall, 1'b0);
        chk32("rst_dma_rdata", dma_rdata, 32'h0);
        reset = 1'b0;
        tick();

        // CPU lw / sw at 0x10 with no requester
        cpu_rd = 1'b1; cpu_addr = 32'h0000_0010;
        #1;
        chk1("lw_mem_rd", mem_rd, 1'b1);
        chk32("lw_mem_addr", mem_addr, 32'h0000_0010);
        chk32("lw_cpu_rdata", cpu_rdata, 32'hDEAD_0010);
        chk1("lw_stall", cpu_stall, 1'b0);
        tick();
        cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_wdata = 32'h1234_5678;
        #1;
        chk1("sw_mem_wr", mem_wr, 1'b1);
        chk1("sw_mem_rd", mem_rd, 1'b0);
        chk32("sw_mem_wdata", mem_wdata, 32'h1234_5678);
        tick();

        // Idle CPU, 4-beat write burst to 0x100..0x10C
        cpu_wr = 1'b0;
        dma_req = 1'b1; dma_wr = 1'b1; dma_burst = 4'd3; dma_addr = 32'h100;
        #1;
        chk1("b4_gnt_t0", dma_gnt, 1'b0);
        for (int b = 0; b < 4; b++) begin
            tick();
            dma_addr  = 32'h100 + 32'(4 * b);
            dma_wdata = 32'hA000_0000 + 32'(b);
            #1;
            chk1("b4_gnt", dma_gnt, 1'b1);
            chk1("b4_mem_wr", mem_wr, 1'b1);
            chk32("b4_mem_addr", mem_addr, 32'h100 + 32'(4 * b));
            chk32("b4_mem_wdata", mem_wdata, 32'hA000_0000 + 32'(b));
            chk1("b4_done", dma_done, (b == 3));
        end
        tick();
        chk1("b4_gnt_after", dma_gnt, 1'b0);
        dma_req = 1'b0;
        tick();

        // Busy CPU every cycle: forced grant on the 9th edge
        cpu_rd = 1'b1; cpu_addr = 32'h20;
        dma_req = 1'b1; dma_wr = 1'b0; dma_burst = 4'd1; dma_addr = 32'h200;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk1("stv_gnt_wait", dma_gnt, 1'b0);
            chk1("stv_stall_wait", cpu_stall, 1'b0);
        end
        tick();
        chk1("stv_gnt", dma_gnt, 1'b1);
        chk1("stv_stall", cpu_stall, 1'b1);
        chk1("stv_mem_rd", mem_rd, 1'b1);
        chk32("stv_mem_addr", mem_addr, 32'h200);
        chk32("stv_dma_rdata", dma_rdata, 32'hDEAD_0200);
        chk32("stv_cpu_rdata", cpu_rdata, 32'h0);
        tick();
        dma_addr = 32'h204;
        #1;
        chk1("stv_stall2", cpu_stall, 1'b1);
        chk1("stv_done", dma_done, 1'b1);
        tick();
        dma_req = 1'b0;
        #1;
        chk1("stv_gnt_end", dma_gnt, 1'b0);
        chk1("stv_stall_end", cpu_stall, 1'b0);
        chk32("stv_cpu_back", cpu_rdata, 32'hDEAD_0020);
        tick();

        // Abort after 2 of 5 beats
        cpu_rd = 1'b0;
        dma_req = 1'b1; dma_wr = 1'b1; dma_burst = 4'd4; dma_addr = 32'h300;
        tick();
        chk1("ab_gnt0", dma_gnt, 1'b1);
        tick();
        dma_addr = 32'h304;
        #1;
        chk1("ab_gnt1", dma_gnt, 1'b1);
        chk1("ab_done1", dma_done, 1'b0);
        tick();
        dma_req = 1'b0; dma_addr = 32'h308;
        #1;
        chk1("ab_no_wr", mem_wr, 1'b0);
        chk1("ab_no_rd", mem_rd, 1'b0);
        chk1("ab_no_done", dma_done, 1'b0);
        chk1("ab_no_gnt", dma_gnt, 1'b0);
        tick();
        chk1("ab_state", dut.state_q, S_CPU);

        // Back-to-back single-beat bursts, requester held high
        dma_req = 1'b1; dma_burst = 4'd0; dma_addr = 32'h400;
        tick();
        chk1("bb_gnt_a", dma_gnt, 1'b1);
        chk1("bb_done_a", dma_done, 1'b1);
        tick();
        chk1("bb_gap_gnt", dma_gnt, 1'b0);
        chk1("bb_gap_state", dut.state_q, S_CPU);
        tick();
        chk1("bb_gnt_b", dma_gnt, 1'b1);
        chk1("bb_done_b", dma_done, 1'b1);
        tick();
        dma_req = 1'b0;
        tick();

        // Reset during beat 2 of 4
        dma_req = 1'b1; dma_wr = 1'b1; dma_burst = 4'd3; dma_addr = 32'h500;
        tick();
        tick();
        chk1("rm_gnt_b2", dma_gnt, 1'b1);
        cpu_wr = 1'b1; cpu_addr = 32'h44; cpu_wdata = 32'h55;
        reset = 1'b1;
        #1;
        chk1("rm_gnt", dma_gnt, 1'b0);
        chk1("rm_mem_wr", mem_wr, 1'b1);
        chk32("rm_mem_addr", mem_addr, 32'h44);
        chk1("rm_done", dma_done, 1'b0);
        tick();
        dma_req = 1'b0; cpu_wr = 1'b0;
        reset = 1'b0;
        #1;
        chk32("rm_beat_cnt", 32'(dut.beat_cnt_q), 32'h0);
        chk32("rm_wait_cnt", 32'(dut.u_starve.cnt_q), 32'h0);
        chk1("rm_state", dut.state_q, S_CPU);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter for the shared data-memory bus (data memory, peripheral and UART windows behind one rd/wr/addr/wdata port). It lets a DMA-style requester, such as the UART boot loader or a block-copy engine, share the bus with the single-cycle CPU core. The CPU keeps priority, and a starvation counter bounds the requester's wait. While the requester holds the bus, the arbiter raises a stall to the PC unit so the CPU's access is retried.

## Interface
- STARVE_LIMIT, 8: consecutive blocked cycles after which a waiting DMA request is forced through (range 1–255).
- BURST_W, 4: width of the burst-length field; maximum burst is 2^BURST_W beats.
- clk  in  1  system clock (divided CPU clock)
- reset  in  1  asynchronous, active-high
- cpu_rd, cpu_wr  in  1  CPU read/write strobes
- cpu_addr, cpu_wdata  in  32  CPU address / write data
- cpu_rdata  out  32  read data to CPU; 0 when the CPU is not bus owner
- cpu_stall  out  1  hold PC and suppress RegWr this cycle
- dma_req  in  1  requester wants the bus; held until dma_done
- dma_wr  in  1  1 = write beat, 0 = read beat
- dma_addr, dma_wdata  in  32  requester address / data, updated by requester each beat
- dma_burst  in  BURST_W  beats minus 1; sampled on grant
- dma_gnt  out  1  bus owned by requester this cycle
- dma_rdata  out  32  read data to requester; 0 when not owner
- dma_done  out  1  high during final beat
- mem_rd, mem_wr  out  1  shared-bus strobes
- mem_addr, mem_wdata  out  32  shared-bus address / data
- mem_rdata  in  32  OR-combined read data from all slaves (combinational read)

## Operation
- State machine with two states:
  - S_CPU: the bus mirrors the cpu_* inputs. dma_gnt = 0, cpu_stall = 0.
  - S_DMA: mem_addr = dma_addr, mem_wdata = dma_wdata, mem_wr = dma_req & dma_wr, mem_rd = dma_req & ~dma_wr. dma_gnt = dma_req. cpu_stall = cpu_rd | cpu_wr. CPU strobes are never forwarded.
- Transition S_CPU→S_DMA at a clock edge when dma_req=1 and either:
  - the CPU is idle (cpu_rd=cpu_wr=0), or
  - wait_cnt == STARVE_LIMIT (forced grant).
- On entry to S_DMA: load beat_cnt ← dma_burst and clear wait_cnt.
- wait_cnt behaviour:
  - increments in S_CPU when dma_req=1 and the CPU is accessing;
  - saturates at STARVE_LIMIT;
  - clears when dma_req=0.
- In S_DMA each cycle with dma_req=1 performs one beat and decrements beat_cnt.
- dma_done = (state==S_DMA) & dma_req & (beat_cnt==0). On that edge, return to S_CPU.
- Abort: if dma_req=0 in S_DMA, no bus access occurs, dma_done stays 0, and the next state is S_CPU.
- After any burst the arbiter spends at least one cycle in S_CPU. It re-grants on the following edge only if the entry conditions hold.
- cpu_rdata = mem_rdata in S_CPU, else 0. dma_rdata = mem_rdata in S_DMA, else 0.

## Timing
- Reset values: state S_CPU, beat_cnt 0, wait_cnt 0. Hence dma_gnt=0, dma_done=0, cpu_stall=0 and dma_rdata=0; the mem_* outputs follow the cpu_* inputs.
- Reset asserted mid-burst: return to S_CPU immediately (asynchronous). The burst is lost and no dma_done is issued.
- Grant latency: dma_req seen with an idle CPU in cycle t gives dma_gnt=1 in cycle t+1.
- Worst-case grant latency is STARVE_LIMIT+1 cycles.
- A burst occupies exactly dma_burst+1 cycles when dma_req is held.
- Memory writes commit at the end of the beat cycle. Read data is valid in the same cycle (combinational slaves).
- cpu_stall is combinational from state and the CPU strobes. The CPU re-presents the same access every stalled cycle.
- Simultaneous CPU access and DMA request with wait_cnt<STARVE_LIMIT: the CPU wins and wait_cnt increments.

## Structure
- Shared package dmem_pkg holds:
  - the state typedef (S_CPU, S_DMA);
  - the bus width constant (32);
  - the STARVE_LIMIT and BURST_W defaults, reused by the DMA engine.
- Sub-module starve_counter:
  - saturating counter with inc/clr/sat ports;
  - parameterised by limit.
- The FSM, beat counter and output muxes stay in dmem_arbiter.

## Test plan
- Reset, then CPU lw/sw at 0x0000_0010 with dma_req=0. Required: mem_* mirror the CPU, cpu_stall=0, and cpu_rdata = mem_rdata.
- CPU idle, dma_req=1, dma_burst=3, writes to 0x100..0x10C. Required: dma_gnt high for exactly 4 cycles starting at t+1, 4 writes land, and dma_done is high only in the 4th beat.
- CPU accessing every cycle, dma_req=1, STARVE_LIMIT=8. Required: grant on the 9th edge, and cpu_stall=1 for every CPU access during the burst.
- dma_req dropped after 2 of 5 beats. Required: no third access, no dma_done, and state S_CPU at the next edge.
- Back-to-back bursts with the CPU idle. Required: one S_CPU cycle between bursts, with dma_gnt=0 in that cycle.
- Reset asserted in beat 2 of 4. Required: dma_gnt=0 immediately, mem_wr follows cpu_wr, and the counters read 0 after release.
